// File: rtl/audio_pkg.sv
// Shared types for the playback upsampler: sample type, sequencer states
// and the midpoint helper used by linear interpolation.
package audio_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    PRIME,
    MID,
    HOLD
  } up_state_t;

  // Midpoint of two samples: 17-bit sum, then drop the LSB. The arithmetic
  // shift floors toward minus infinity and the result always fits 16 bits.
  function automatic sample_t interp(input sample_t a, input sample_t b);
    logic signed [SAMPLE_W:0] sum;
    sum = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
    return sum[SAMPLE_W:1];
  endfunction

endpackage

// File: rtl/upsample_audio_if.sv
// Sample/tick bus between the 24 kHz producer, the 48 kHz timing generator
// and the upsampler. master = stimulus side, slave = upsampler side.
interface upsample_audio_if #(
  parameter int FIFO_DEPTH = 8
);
  import audio_pkg::*;

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             sample_in_valid;
  sample_t          sample_in;
  logic             out_tick;
  sample_t          audio_out;
  logic             audio_out_valid;
  logic [LVL_W-1:0] fifo_level;
  logic             underrun;
  logic             overrun;

  modport master (
    output sample_in_valid,
    output sample_in,
    output out_tick,
    input  audio_out,
    input  audio_out_valid,
    input  fifo_level,
    input  underrun,
    input  overrun
  );

  modport slave (
    input  sample_in_valid,
    input  sample_in,
    input  out_tick,
    output audio_out,
    output audio_out_valid,
    output fifo_level,
    output underrun,
    output overrun
  );

endinterface

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through sample FIFO. DEPTH must be a power
// of two so the pointers wrap naturally. When full, a same-cycle pop frees
// the slot first so the push is still accepted.
module sample_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  sample_t                  din,
  output sample_t                  dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  sample_t        mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array: written on accepted pushes only, never cleared.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; reset flushes the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/upsample_audio.sv
// 24 kHz -> 48 kHz playback upsampler. Buffers input samples, waits for
// PRIME_LEVEL entries, then emits sample / midpoint / sample ... on each
// out_tick. Optional macro UPSAMPLE_LINEAR_EN selects linear interpolation
// for the midpoint; without it the midpoint repeats the new sample
// (zero-order hold).
module upsample_audio
  import audio_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int PRIME_LEVEL = 2
) (
  input  logic               audio_clk,
  input  logic               rst_in,
  upsample_audio_if.slave    bus
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LVL_W-1:0] PRIME_LVL = LVL_W'(PRIME_LEVEL);

  up_state_t         state;
  up_state_t         next_state;
  sample_t           cur;
  sample_t           next_cur;
  sample_t           out_q;
  sample_t           next_out;
  sample_t           mid_value;
  logic              out_valid_q;
  logic              underrun_q;
  logic              overrun_q;
  logic              set_underrun;
  logic              set_overrun;
  logic              pop;
  sample_t           fifo_dout;
  logic [LVL_W-1:0]  fifo_level;
  logic              fifo_full;
  logic              fifo_empty;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (audio_clk),
    .rst   (rst_in),
    .push  (bus.sample_in_valid),
    .pop   (pop),
    .din   (bus.sample_in),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef UPSAMPLE_LINEAR_EN
  assign mid_value = interp(cur, fifo_dout);
`else
  assign mid_value = fifo_dout;
`endif

  // A push lost only when the FIFO is full and nothing leaves this cycle.
  assign set_overrun = bus.sample_in_valid && fifo_full && !pop;

  // Sequencer: decides on each tick what to emit and whether to pop.
  // Decisions use the pre-push level, so a same-cycle push cannot rescue
  // an empty FIFO.
  always_comb begin
    next_state   = state;
    next_cur     = cur;
    next_out     = out_q;
    pop          = 1'b0;
    set_underrun = 1'b0;
    if (bus.out_tick) begin
      unique case (state)
        PRIME: begin
          if (fifo_level >= PRIME_LVL) begin
            pop        = 1'b1;
            next_cur   = fifo_dout;
            next_out   = fifo_dout;
            next_state = MID;
          end else begin
            next_out = cur;
          end
        end
        MID: begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            next_cur   = fifo_dout;
            next_out   = mid_value;
            next_state = HOLD;
          end else begin
            next_out     = cur;
            set_underrun = 1'b1;
            next_state   = PRIME;
          end
        end
        HOLD: begin
          next_out   = cur;
          next_state = MID;
        end
        default: begin
          next_state = PRIME;
        end
      endcase
    end
  end

  // State, held sample, output register, valid pulse and sticky flags.
  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      state       <= PRIME;
      cur         <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state       <= next_state;
      cur         <= next_cur;
      out_q       <= next_out;
      out_valid_q <= bus.out_tick;
      underrun_q  <= underrun_q | set_underrun;
      overrun_q   <= overrun_q | set_overrun;
    end
  end

  assign bus.audio_out       = out_q;
  assign bus.audio_out_valid = out_valid_q;
  assign bus.fifo_level      = fifo_level;
  assign bus.underrun        = underrun_q;
  assign bus.overrun         = overrun_q;

endmodule

// File: tb/tb_upsample_audio.sv
// Self-checking bench for upsample_audio: a vector table for the basic
// prime/interpolate/underrun and rounding cases, then hand sequences for
// overrun, steady streaming, tick/push coincidence and mid-stream reset.
module tb_upsample_audio;
  import audio_pkg::*;

  localparam int DEPTH = 8;
  localparam int PRIME = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  upsample_audio_if #(.FIFO_DEPTH(DEPTH)) bus ();

  upsample_audio #(
    .FIFO_DEPTH  (DEPTH),
    .PRIME_LEVEL (PRIME)
  ) dut (
    .audio_clk (clk),
    .rst_in    (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v;
    int   d;
    logic t;
    int   e_out;
    int   e_valid;
    int   e_lvl;
    int   e_under;
    int   e_over;
  } vec_t;

  vec_t vecs [18];

  // Expected midpoint output for the build in use.
  function automatic int mid(input int a, input int b);
`ifdef UPSAMPLE_LINEAR_EN
    return (a + b) >>> 1;
`else
    return b;
`endif
  endfunction

  function automatic vec_t mk(input logic v, input int d, input logic t,
                              input int eo, input int ev, input int el,
                              input int eu, input int eov);
    vec_t r;
    r.v = v; r.d = d; r.t = t;
    r.e_out = eo; r.e_valid = ev; r.e_lvl = el; r.e_under = eu; r.e_over = eov;
    return r;
  endfunction

  task automatic compare(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input int d, input logic t);
    bus.sample_in_valid = v;
    bus.sample_in       = sample_t'(d);
    bus.out_tick        = t;
    @(posedge clk);
    #1;
    bus.sample_in_valid = 1'b0;
    bus.sample_in       = '0;
    bus.out_tick        = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int e_out, input int e_valid,
                             input int e_lvl, input int e_under, input int e_over);
    compare({name, ".audio_out"},       int'(bus.audio_out),       e_out);
    compare({name, ".audio_out_valid"}, int'(bus.audio_out_valid), e_valid);
    compare({name, ".fifo_level"},      int'(bus.fifo_level),      e_lvl);
    compare({name, ".underrun"},        int'(bus.underrun),        e_under);
    compare({name, ".overrun"},         int'(bus.overrun),         e_over);
  endtask

  task automatic doReset(input logic tick);
    rst          = 1'b1;
    bus.out_tick = tick;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.out_tick = 1'b0;
  endtask

  initial begin
    int cur_m;
    int j;
    int lvl;

    bus.sample_in_valid = 1'b0;
    bus.sample_in       = '0;
    bus.out_tick        = 1'b0;

    // Table: prime, interpolate, underrun, then rounding extremes.
    vecs[0]  = mk(1, 100,    0, 0,                  0, 1, 0, 0);
    vecs[1]  = mk(1, 201,    0, 0,                  0, 2, 0, 0);
    vecs[2]  = mk(0, 0,      1, 100,                1, 1, 0, 0);
    vecs[3]  = mk(0, 0,      0, 100,                0, 1, 0, 0);
    vecs[4]  = mk(0, 0,      1, mid(100, 201),      1, 0, 0, 0);
    vecs[5]  = mk(0, 0,      1, 201,                1, 0, 0, 0);
    vecs[6]  = mk(0, 0,      1, 201,                1, 0, 1, 0);
    vecs[7]  = mk(0, 0,      1, 201,                1, 0, 1, 0);
    vecs[8]  = mk(1, -1,     0, 201,                0, 1, 1, 0);
    vecs[9]  = mk(1, 0,      0, 201,                0, 2, 1, 0);
    vecs[10] = mk(0, 0,      1, -1,                 1, 1, 1, 0);
    vecs[11] = mk(0, 0,      1, mid(-1, 0),         1, 0, 1, 0);
    vecs[12] = mk(0, 0,      1, 0,                  1, 0, 1, 0);
    vecs[13] = mk(1, -32768, 0, 0,                  0, 1, 1, 0);
    vecs[14] = mk(0, 0,      1, mid(0, -32768),     1, 0, 1, 0);
    vecs[15] = mk(1, 32767,  0, mid(0, -32768),     0, 1, 1, 0);
    vecs[16] = mk(0, 0,      1, -32768,             1, 1, 1, 0);
    vecs[17] = mk(0, 0,      1, mid(-32768, 32767), 1, 0, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset", 0, 0, 0, 0, 0);

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].v, vecs[i].d, vecs[i].t);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_valid,
                  vecs[i].e_lvl, vecs[i].e_under, vecs[i].e_over);
    end

    // Fill to full, push+pop while full, then a dropped push.
    doReset(1'b0);
    for (int i = 1; i <= DEPTH; i++) begin
      applyStimulus(1'b1, i, 1'b0);
      compare($sformatf("fill%0d.fifo_level", i), int'(bus.fifo_level), i);
      compare($sformatf("fill%0d.overrun", i), int'(bus.overrun), 0);
    end
    applyStimulus(1'b1, 9, 1'b1);
    checkOutput("full_push_pop", 1, 1, 8, 0, 0);
    applyStimulus(1'b1, 10, 1'b0);
    checkOutput("overrun", 1, 0, 8, 0, 1);
    cur_m = 1;
    for (int s = 2; s <= 9; s++) begin
      applyStimulus(1'b0, 0, 1'b1);
      checkOutput($sformatf("drain_mid%0d", s), mid(cur_m, s), 1, 9 - s, 0, 1);
      applyStimulus(1'b0, 0, 1'b1);
      checkOutput($sformatf("drain_hold%0d", s), s, 1, 9 - s, 0, 1);
      cur_m = s;
    end
    applyStimulus(1'b0, 0, 1'b1);
    checkOutput("drain_underrun", 9, 1, 0, 1, 1);

    // Steady stream: ramp 0,10,20,... at one push per two ticks.
    doReset(1'b0);
    applyStimulus(1'b1, 0, 1'b0);
    applyStimulus(1'b1, 10, 1'b0);
    j = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 10 * (k + 2), 1'b0);
      compare($sformatf("stream_push%0d.audio_out_valid", k), int'(bus.audio_out_valid), 0);
      for (int p = 0; p < 2; p++) begin
        applyStimulus(1'b0, 0, 1'b1);
        lvl = int'(bus.fifo_level);
        compare($sformatf("stream%0d.audio_out", j), int'(bus.audio_out),
                (j % 2 == 0) ? 10 * (j / 2) : mid(10 * ((j - 1) / 2), 10 * ((j + 1) / 2)));
        compare($sformatf("stream%0d.audio_out_valid", j), int'(bus.audio_out_valid), 1);
        compare($sformatf("stream%0d.level_in_range lvl=%0d", j, lvl),
                int'(lvl >= 1 && lvl <= PRIME + 1), 1);
        compare($sformatf("stream%0d.flags", j), int'({bus.underrun, bus.overrun}), 0);
        j++;
      end
    end

    // Tick coinciding with a push on an empty FIFO underruns but keeps the sample.
    doReset(1'b0);
    applyStimulus(1'b1, 1, 1'b0);
    applyStimulus(1'b1, 2, 1'b0);
    applyStimulus(1'b0, 0, 1'b1);
    checkOutput("co_prime", 1, 1, 1, 0, 0);
    applyStimulus(1'b0, 0, 1'b1);
    checkOutput("co_mid", mid(1, 2), 1, 0, 0, 0);
    applyStimulus(1'b0, 0, 1'b1);
    checkOutput("co_hold", 2, 1, 0, 0, 0);
    applyStimulus(1'b1, 3, 1'b1);
    checkOutput("co_underrun", 2, 1, 1, 1, 0);
    applyStimulus(1'b1, 4, 1'b0);
    applyStimulus(1'b0, 0, 1'b1);
    checkOutput("co_reprime", 3, 1, 1, 1, 0);
    applyStimulus(1'b1, 5, 1'b0);
    applyStimulus(1'b1, 6, 1'b0);
    checkOutput("pre_reset", 3, 0, 3, 1, 0);

    // Reset mid-stream, with a tick held high to show no valid pulse.
    doReset(1'b1);
    checkOutput("mid_reset", 0, 0, 0, 0, 0);
    applyStimulus(1'b0, 0, 1'b1);
    checkOutput("post_reset_t0", 0, 1, 0, 0, 0);
    applyStimulus(1'b1, 7, 1'b0);
    applyStimulus(1'b0, 0, 1'b1);
    checkOutput("post_reset_t1", 0, 1, 1, 0, 0);
    applyStimulus(1'b1, 8, 1'b0);
    applyStimulus(1'b0, 0, 1'b1);
    checkOutput("post_reset_t2", 7, 1, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/upsample_audio.md
Name: upsample_audio

Overview:
- Playback-side counterpart of the capture chain: accepts 24 kHz processed samples and produces a 48 kHz stream for the DAC/speaker path.
- Buffers input in a small FIFO, primes before starting, and interpolates 2x on a 48 kHz output tick.
- Sits between the 24 kHz processing/output domain and the DAC driver. Everything runs on audio_clk.

Parameters:
- FIFO_DEPTH, 8, input FIFO entries; must be a power of 2 and at least 4.
- PRIME_LEVEL, 2, FIFO occupancy needed to leave PRIME; range 1..FIFO_DEPTH.

Ports:
- audio_clk  in  1  system audio clock
- rst_in  in  1  synchronous, active-high reset
- sample_in_valid  in  1  single-cycle strobe, one per 24 kHz input sample
- sample_in  in  16  signed input sample, valid with sample_in_valid
- out_tick  in  1  single-cycle 48 kHz output strobe from the timing generator
- audio_out  out  16  signed output sample, registered
- audio_out_valid  out  1  single-cycle pulse, one cycle after each out_tick
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- underrun  out  1  sticky; set on a MID tick with an empty FIFO
- overrun  out  1  sticky; set on a push into a full FIFO

Behaviour:
- Clock and reset: single clock audio_clk; rst_in is synchronous and active-high.
- Reset values: audio_out=0, audio_out_valid=0, fifo_level=0, underrun=0, overrun=0, cur=0, state=PRIME.
- Push: sample_in_valid writes sample_in to the FIFO tail.
  - If the FIFO is full and no pop happens that cycle, the new sample is dropped and overrun is set.
  - If push and pop occur in the same cycle while full, the pop happens first, the push is accepted, and the level is unchanged.
- Output cadence: every out_tick produces exactly one audio_out update, with audio_out_valid=1 on the next cycle, in every state. Latency is 1 cycle from out_tick.
- PRIME state (on out_tick):
  - If fifo_level >= PRIME_LEVEL: pop x into cur, audio_out<=x, go to MID.
  - Otherwise: audio_out<=cur (0 after reset, last sample after an underrun) and stay in PRIME.
- MID state (on out_tick):
  - If the FIFO is non-empty: pop n, audio_out<=interp(cur,n), cur<=n, go to HOLD.
  - If empty: audio_out<=cur, set underrun, go to PRIME.
- HOLD state (on out_tick): audio_out<=cur, go to MID. No pop.
- Resulting steady-state sequence: x0, mid(x0,x1), x1, mid(x1,x2), x2, ... The block consumes one input per two ticks.
- interp(a,b): form the 17-bit signed sum a+b, arithmetic shift right by 1 (floor), take the low 16 bits. It cannot overflow.
- out_tick coinciding with sample_in_valid on an empty FIFO: the pop decision uses the pre-push level, so the block underruns. The new sample is still stored.
- Without a tick, state, cur and audio_out do not change.
- fifo_level and the sticky flags update in the cycle after the event. Only rst_in clears the sticky flags.
- Reset asserted mid-stream: the FIFO is flushed, all state returns to reset values on the next edge, and no audio_out_valid pulse occurs during reset.

Optional Feature:
- Macro: UPSAMPLE_LINEAR_EN
- Defined: MID outputs interp(cur,n) as above (linear interpolation).
- Undefined: MID outputs n directly, giving zero-order hold (x0, x1, x1, x2, x2, ...). The interp adder is not synthesized. All other behaviour, including flags, is identical.

Decomposition:
- Shared package audio_pkg:
  - sample_t (logic signed [15:0])
  - up_state_t enum {PRIME, MID, HOLD}
  - constant SAMPLE_W=16
- One sub-module, sample_fifo: synchronous FIFO.
  - Parameter DEPTH.
  - Ports: push, pop, din, dout (first-word fall-through), level, full, empty.
  - Pop-before-push when full.
  - Overrun detection stays in the parent.

Test Plan:
1. Reset, push 100 then 201, then 4 out_ticks (macro defined) -> audio_out = 100, 150, 201, 201; audio_out_valid pulses one cycle after each tick; underrun=1 after the 4th tick (2nd MID with empty FIFO).
2. Rounding: cur=-1, n=0, then cur=-32768, n=32767 -> mid outputs -1 and -1; no wrap.
3. Overrun: push 9 samples with no ticks (FIFO_DEPTH=8) -> fifo_level=8, overrun=1, 9th sample absent from later output.
4. Steady stream: 24 kHz push with 48 kHz ticks, ramp 0,10,20,... -> output 0,5,10,15,...; no underrun/overrun; fifo_level stays within 1..PRIME_LEVEL+1.
5. Macro undefined, inputs 100, 200, 300 -> audio_out = 100, 200, 200, 300, 300.
6. rst_in asserted for 1 cycle mid-stream with level=3 -> next cycle fifo_level=0, audio_out=0, flags=0, state=PRIME; following ticks output 0 until PRIME_LEVEL samples arrive.
